// File: rtl/pwm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : pwm_pkg                                                 |
// | Purpose : Shared types and constants for the PWM capture slice.  |
// |           cap_state_t enumerates the capture FSM states;          |
// |           PWM8_PERIOD is the period of the 8-bit PWM generator.   |
// | Revision: 1.0 - initial release                                   |
// +------------------------------------------------------------------+
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    STUCK = 2'd3
  } cap_state_t;

  localparam int PWM8_PERIOD = 256;

endpackage
`default_nettype wire

// File: rtl/pwm8_capture_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface: pwm8_capture_if                                        |
// | Purpose  : Bundles the PWM input and the measurement results.     |
// |   PWM_sig     - PWM waveform (asynchronous to clk)                |
// |   duty_meas   - high cycles of the last completed period          |
// |   period_meas - rise-to-rise cycles of the last completed period  |
// |   meas_vld    - one-cycle strobe on result update                 |
// |   stuck_lo    - input held low past the timeout                   |
// |   stuck_hi    - input held high past the timeout                  |
// | Modports : master = capture block, slave = PWM source / consumer  |
// | Revision : 1.0 - initial release                                  |
// +------------------------------------------------------------------+
interface pwm8_capture_if #(
  parameter int CNT_W = 9
);
  logic             PWM_sig;
  logic [CNT_W-1:0] duty_meas;
  logic [CNT_W-1:0] period_meas;
  logic             meas_vld;
  logic             stuck_lo;
  logic             stuck_hi;

  modport master (
    input  PWM_sig,
    output duty_meas, period_meas, meas_vld, stuck_lo, stuck_hi
  );

  modport slave (
    output PWM_sig,
    input  duty_meas, period_meas, meas_vld, stuck_lo, stuck_hi
  );
endinterface
`default_nettype wire

// File: rtl/pwm8_capture_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : sync_edge_det                                           |
// | Purpose : Two-flop synchroniser plus one delay flop; produces the |
// |           synchronised level and single-cycle rise/fall strobes.  |
// | Ports   : clk, rst  - clock, synchronous active-high reset        |
// |           d_i       - asynchronous input                          |
// |           level_o   - synchronised level (s2)                     |
// |           rise_o    - s2 & ~s3                                    |
// |           fall_o    - ~s2 & s3                                    |
// | Revision: 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module sync_edge_det (
  input  wire  clk,
  input  wire  rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;
  assign fall_o  = ~s2_q & s3_q;

endmodule
`default_nettype wire

// File: rtl/pwm8_capture.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : pwm8_capture                                            |
// | Purpose : Measures high time and period of a PWM input in clk     |
// |           cycles, strobing meas_vld once per completed period,    |
// |           and flags a stuck-low/high input after TIMEOUT          |
// |           edge-free cycles.                                       |
// | Ports   : clk  - system clock                                     |
// |           rst  - synchronous active-high reset                    |
// |           cap  - pwm8_capture_if.master (PWM_sig in, results out) |
// | Revision: 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module pwm8_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 9,
  parameter int TIMEOUT = 511
) (
  input wire              clk,
  input wire              rst,
  pwm8_capture_if.master  cap
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic level;
  logic rise;
  logic fall;

  sync_edge_det u_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (cap.PWM_sig),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  cap_state_t       state_q;
  logic [CNT_W-1:0] hi_cnt_q;
  logic [CNT_W-1:0] per_cnt_q;
  logic [CNT_W-1:0] to_cnt_q;
  logic [CNT_W-1:0] duty_q;
  logic [CNT_W-1:0] period_q;
  logic             vld_q;
  logic             stuck_lo_q;
  logic             stuck_hi_q;

  // Saturating increments: counters stick at all-ones instead of wrapping.
  logic [CNT_W-1:0] hi_inc;
  logic [CNT_W-1:0] per_inc;
  logic [CNT_W-1:0] to_inc;
  logic             timeout;

  always_comb begin
    hi_inc  = (hi_cnt_q  == CNT_MAX) ? hi_cnt_q  : hi_cnt_q  + CNT_ONE;
    per_inc = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_ONE;
    to_inc  = (to_cnt_q  == CNT_MAX) ? to_cnt_q  : to_cnt_q  + CNT_ONE;
    // An edge in the same cycle suppresses the timeout.
    timeout = (state_q != STUCK) && !rise && !fall && (to_cnt_q == TO_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hi_cnt_q   <= '0;
      per_cnt_q  <= '0;
      to_cnt_q   <= '0;
      duty_q     <= '0;
      period_q   <= '0;
      vld_q      <= 1'b0;
      stuck_lo_q <= 1'b0;
      stuck_hi_q <= 1'b0;
    end else begin
      vld_q    <= 1'b0;
      to_cnt_q <= (rise || fall) ? '0 : to_inc;

      if (timeout) begin
        vld_q   <= 1'b1;
        state_q <= STUCK;
        if (level) begin
          stuck_hi_q <= 1'b1;
          duty_q     <= CNT_MAX;
          period_q   <= CNT_MAX;
        end else begin
          stuck_lo_q <= 1'b1;
          duty_q     <= '0;
          period_q   <= '0;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              hi_cnt_q  <= CNT_ONE;
              per_cnt_q <= CNT_ONE;
              state_q   <= HIGH;
            end
          end
          HIGH: begin
            // The fall cycle itself is a low cycle: it counts toward the
            // period but not the high time.
            per_cnt_q <= per_inc;
            if (fall) begin
              state_q <= LOW;
            end else begin
              hi_cnt_q <= hi_inc;
            end
          end
          LOW: begin
            if (rise) begin
              duty_q    <= hi_cnt_q;
              period_q  <= per_cnt_q;
              vld_q     <= 1'b1;
              hi_cnt_q  <= CNT_ONE;
              per_cnt_q <= CNT_ONE;
              state_q   <= HIGH;
            end else begin
              per_cnt_q <= per_inc;
            end
          end
          STUCK: begin
            if (rise) begin
              stuck_lo_q <= 1'b0;
              stuck_hi_q <= 1'b0;
              hi_cnt_q   <= CNT_ONE;
              per_cnt_q  <= CNT_ONE;
              state_q    <= HIGH;
            end else if (fall) begin
              stuck_lo_q <= 1'b0;
              stuck_hi_q <= 1'b0;
              state_q    <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign cap.duty_meas   = duty_q;
  assign cap.period_meas = period_q;
  assign cap.meas_vld    = vld_q;
  assign cap.stuck_lo    = stuck_lo_q;
  assign cap.stuck_hi    = stuck_hi_q;

endmodule
`default_nettype wire
